// File: rtl/btn_event_arbiter.sv
// Button event arbiter: latches rising edges from four level requests,
// offers them one at a time to a consumer with fixed priority (bit0 first),
// waits for an acknowledge (with optional timeout), then enforces a lockout.
module btn_event_arbiter #(
  parameter int HOLDOFF     = 25000000,
  parameter int ACK_TIMEOUT = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  input  logic       ev_ack,
  output logic       ev_valid,
  output logic [1:0] ev_id,
  output logic [3:0] pending,
  output logic       busy,
  output logic       drop
);

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int GW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF - 1);
  localparam logic [GW-1:0] GRANT_LAST = GW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [3:0]      req_prev;
  logic [3:0]      rise;
  logic [3:0]      clr;
  logic [1:0]      sel;
  logic [3:0]      pending_next;
  logic            ev_valid_next;
  logic [1:0]      ev_id_next;
  logic            drop_next;
  logic [GW-1:0]   grant_cnt, grant_cnt_next;
  logic [HW-1:0]   hold_cnt, hold_cnt_next;

  // Busy is a pure decode of the state; all other outputs are registered.
  assign busy = (state != IDLE);

  // Next-state, counter and output computation for the arbiter FSM.
  // NOTE: every variable gets a default first so no path leaves one unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    state_next     = state;
    ev_valid_next  = ev_valid;
    ev_id_next     = ev_id;
    drop_next      = 1'b0;
    grant_cnt_next = grant_cnt;
    hold_cnt_next  = hold_cnt;
    clr            = 4'b0000;
    sel            = 2'd0;
    rise           = req_in & ~req_prev;

    // Lowest index wins: scan high to low so the last hit is the lowest bit.
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) sel = 2'(i);
    end

    case (state)
      IDLE: begin
        if (|pending) begin
          state_next     = GRANT;
          ev_valid_next  = 1'b1;
          ev_id_next     = sel;
          clr[sel]       = 1'b1;
          grant_cnt_next = '0;
        end
      end
      GRANT: begin
        if (ev_ack) begin
          state_next    = HOLD;
          ev_valid_next = 1'b0;
          hold_cnt_next = '0;
        end else if ((ACK_TIMEOUT != 0) && (grant_cnt == GRANT_LAST)) begin
          state_next    = HOLD;
          ev_valid_next = 1'b0;
          drop_next     = 1'b1;
          hold_cnt_next = '0;
        end else if (ACK_TIMEOUT != 0) begin
          grant_cnt_next = grant_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        ev_valid_next = 1'b0;
      end
    endcase

    // A new edge on the bit being granted takes precedence over its clear.
    pending_next = (pending & ~clr) | rise;
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_prev  <= req_in;  // buttons held through reset produce no edge
      pending   <= 4'b0000;
      ev_valid  <= 1'b0;
      ev_id     <= 2'd0;
      drop      <= 1'b0;
      grant_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_next;
      req_prev  <= req_in;
      pending   <= pending_next;
      ev_valid  <= ev_valid_next;
      ev_id     <= ev_id_next;
      drop      <= drop_next;
      grant_cnt <= grant_cnt_next;
      hold_cnt  <= hold_cnt_next;
    end
  end

endmodule
